parca_uretici: RTL

Piece source for the `tetris` block: drives its `parca` input with one 3-bit piece code per clock from an 8-bit LFSR. It reacts to the game's `bitti_mi` and `yukseklik` feedback by halting or pausing, and counts issued pieces. It sits directly upstream of `tetris` on the same `clk`, replacing hand-driven piece stimulus.

---
 rtl/parca_uretici.sv | 105 ++++++++++
 1 files changed

// File: rtl/parca_uretici.sv
// Piece source for the tetris block: one 3-bit piece code per clock from an
// 8-bit Fibonacci LFSR, halted by game over, paused by stack height.
module parca_uretici #(
   parameter logic [7:0] TOHUM     = 8'h01,
   parameter logic [7:0] MAX_PARCA = 8'd200,
   parameter logic [3:0] ESIK      = 4'd12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       basla,
   input  logic       bitti_mi,
   input  logic [3:0] yukseklik,
   output logic [2:0] parca,
   output logic       parca_gecerli,
   output logic [2:0] sonraki,
   output logic [7:0] sayac,
   output logic [1:0] durum
);

   localparam logic [1:0] BOSTA = 2'b00;
   localparam logic [1:0] CALIS = 2'b01;
   localparam logic [1:0] BITTI = 2'b10;

   logic [1:0] durum_q, durum_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [7:0] sayac_q, sayac_d;
   logic [2:0] parca_q, parca_d;
   logic       gecerli_q, gecerli_d;

   logic [7:0] lfsr_sonraki;
   logic [7:0] sayac_art;
   logic       duraklat;

   // Code 000 means "no piece", so a zero LFSR slice maps to type 1.
   function automatic logic [2:0] map_f(input logic [2:0] x);
      return (x == 3'b000) ? 3'b001 : x;
   endfunction

   assign lfsr_sonraki = {lfsr_q[6:0],
                          lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign sayac_art    = sayac_q + 8'd1;
   assign duraklat     = (yukseklik >= ESIK);

   always_comb begin
      durum_d   = durum_q;
      lfsr_d    = lfsr_q;
      sayac_d   = sayac_q;
      parca_d   = 3'b000;
      gecerli_d = 1'b0;
      unique case (durum_q)
         BOSTA: begin
            if (basla) begin
               durum_d = CALIS;
               sayac_d = 8'd0;
            end
         end
         CALIS: begin
            if (bitti_mi) begin
               durum_d = BITTI;
            end else if (!duraklat) begin
               parca_d   = map_f(lfsr_q[2:0]);
               gecerli_d = 1'b1;
               lfsr_d    = lfsr_sonraki;
               sayac_d   = sayac_art;
               if (sayac_art == MAX_PARCA) begin
                  durum_d = BITTI;
               end
            end
         end
         BITTI: begin
            // LFSR is deliberately not reseeded on restart.
            if (basla) begin
               durum_d = CALIS;
               sayac_d = 8'd0;
            end
         end
         default: begin
            durum_d = BOSTA;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         durum_q   <= BOSTA;
         lfsr_q    <= TOHUM;
         sayac_q   <= 8'd0;
         parca_q   <= 3'b000;
         gecerli_q <= 1'b0;
      end else begin
         durum_q   <= durum_d;
         lfsr_q    <= lfsr_d;
         sayac_q   <= sayac_d;
         parca_q   <= parca_d;
         gecerli_q <= gecerli_d;
      end
   end

   assign parca         = parca_q;
   assign parca_gecerli = gecerli_q;
   assign sonraki       = map_f(lfsr_q[2:0]);
   assign sayac         = sayac_q;
   assign durum         = durum_q;

endmodule
